// File: rtl/pp_reduce_seq.sv
// Sequential carry-save reducer: sums NUM_PP signed 2N-bit partial products, PP_PER_CYCLE per cycle.
// Optional sticky output over the final sum LSBs is enabled by defining PP_REDUCE_STICKY_EN.
`timescale 1ns/1ps

module pp_reduce_seq #(
  parameter int unsigned N            = 24,
  parameter int unsigned NUM_PP       = 13,
  parameter int unsigned PP_PER_CYCLE = 4,
  parameter int unsigned STICKY_LSBS  = 22
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_PP*2*N-1:0]   pp_array_flat,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [2*N-1:0]          sum
`ifdef PP_REDUCE_STICKY_EN
  ,
  output logic                    sticky
`endif
);

  localparam int unsigned W     = 2 * N;
  localparam int unsigned K     = PP_PER_CYCLE;
  localparam int unsigned G     = (NUM_PP + K - 1) / K;
  localparam int unsigned CNT_W = (G > 1) ? $clog2(G) : 1;
  localparam int unsigned IN_W  = NUM_PP * W;
  localparam int unsigned PAD_W = G * K * W;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_ACCUM   = 2'd1;
  localparam logic [1:0] ST_RESOLVE = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  // Elaboration-time parameter range checks
  if (PP_PER_CYCLE < 1 || PP_PER_CYCLE > NUM_PP) begin : g_bad_k
    $error("pp_reduce_seq: PP_PER_CYCLE out of range");
  end
  if (STICKY_LSBS < 1 || STICKY_LSBS > W) begin : g_bad_sticky
    $error("pp_reduce_seq: STICKY_LSBS out of range");
  end

  logic [1:0]       r_state;
  logic [1:0]       w_state_nxt;
  logic             w_accept;
  logic             w_in_ready;
  logic             w_last;
  logic [IN_W-1:0]  r_pp;
  logic [PAD_W-1:0] w_pp_pad;
  logic [K*W-1:0]   w_grp;
  logic [W-1:0]     r_s;
  logic [W-1:0]     r_c;
  logic [CNT_W-1:0] r_cnt;
  logic [W-1:0]     w_s_nxt;
  logic [W-1:0]     w_c_nxt;
  logic [W-1:0]     w_s_t;
  logic [W-1:0]     w_s_v;
  logic [W-1:0]     w_c_v;
  logic [W-1:0]     w_p_v;
  logic [W-1:0]     w_sum_res;
  logic [W-1:0]     r_sum;
  logic             r_out_valid;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and handshake decode
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_in_ready  = 1'b0;
    w_last      = (r_cnt == CNT_W'(G - 1));
    case (r_state)
      ST_IDLE: begin
        w_in_ready = 1'b1;
        if (in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (w_last) begin
          w_state_nxt = ST_RESOLVE;
        end
      end
      ST_RESOLVE: begin
        w_state_nxt = ST_DONE;
      end
      ST_DONE: begin
        if (out_ready) begin
          w_in_ready = 1'b1;
          if (in_valid) begin
            w_accept    = 1'b1;
            w_state_nxt = ST_ACCUM;
          end else begin
            w_state_nxt = ST_IDLE;
          end
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // Last group is zero-padded up to K slots
  assign w_pp_pad = PAD_W'(r_pp);

  always_comb begin
    w_grp = '0;
    for (int unsigned g = 0; g < G; g++) begin
      if (r_cnt == CNT_W'(g)) begin
        w_grp = w_pp_pad[g*K*W +: K*W];
      end
    end
  end

  // Chain of 3:2 compressors folding K products into the (S, C) pair
  always_comb begin
    w_s_v = r_s;
    w_c_v = r_c;
    w_p_v = '0;
    w_s_t = '0;
    for (int unsigned k = 0; k < K; k++) begin
      w_p_v = w_grp[k*W +: W];
      w_s_t = w_s_v ^ w_c_v ^ w_p_v;
      w_c_v = ((w_s_v & w_c_v) | (w_s_v & w_p_v) | (w_c_v & w_p_v)) << 1;
      w_s_v = w_s_t;
    end
    w_s_nxt = w_s_v;
    w_c_nxt = w_c_v;
  end

  assign w_sum_res = r_s + r_c;

  // Capture, carry-save accumulation and counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_pp  <= '0;
      r_s   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_pp  <= pp_array_flat;
      r_s   <= '0;
      r_c   <= '0;
      r_cnt <= '0;
    end else if (r_state == ST_ACCUM) begin
      r_s   <= w_s_nxt;
      r_c   <= w_c_nxt;
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Result register; sum holds until the next resolve
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum       <= '0;
      r_out_valid <= 1'b0;
    end else if (r_state == ST_RESOLVE) begin
      r_sum       <= w_sum_res;
      r_out_valid <= 1'b1;
    end else if (r_state == ST_DONE && out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

`ifdef PP_REDUCE_STICKY_EN
  logic r_sticky;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sticky <= 1'b0;
    end else if (r_state == ST_RESOLVE) begin
      r_sticky <= |w_sum_res[STICKY_LSBS-1:0];
    end
  end

  assign sticky = r_sticky;
`endif

  assign in_ready  = w_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;

endmodule
